// File: rtl/tid_tracker_pkg.sv
// Shared types for the load transaction-ID tracker:
// per-entry state, entry record and counter sizing.
package tid_tracker_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        KILLED  = 2'd2
    } entry_state_e;

    // Widest requester tag an entry can hold; narrower tags are zero-extended.
    localparam int unsigned MaxTagWidth = 16;

    typedef struct packed {
        entry_state_e           state;
        logic                   nc;
        logic [MaxTagWidth-1:0] tag;
    } entry_t;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/load_tid_tracker_lzc.sv
// Zero counter: MODE 0 counts trailing zeros (index of lowest set bit),
// MODE 1 counts leading zeros. empty_o flags an all-zero input.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    localparam int unsigned CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Priority scan; the last hit in loop order is the one reported.
    always_comb begin
        cnt_o = '0;
        if (MODE) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/load_tid_tracker.sv
// Transaction-ID tracker between the load unit and the memory port:
// grants TIDs, returns stored tags on responses, drops flushed loads.
module load_tid_tracker
    import tid_tracker_pkg::*;
#(
    parameter int unsigned NrEntries      = 8,
    parameter int unsigned TidWidth       = $clog2(NrEntries),
    parameter int unsigned TagWidth       = 4,
    parameter int unsigned MaxOutstanding = NrEntries,
    localparam int unsigned CntWidth      = cnt_width(NrEntries)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic                alloc_nc_i,
    input  logic [TagWidth-1:0] alloc_tag_i,
    output logic [TidWidth-1:0] alloc_tid_o,
    input  logic                rsp_valid_i,
    input  logic [TidWidth-1:0] rsp_tid_i,
    output logic                rsp_valid_o,
    output logic [TagWidth-1:0] rsp_tag_o,
    output logic                spurious_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                empty_o
);

    localparam int unsigned IdxWidth = $clog2(NrEntries);

    entry_t               entries_q [NrEntries];
    entry_t               entries_d [NrEntries];
    logic [NrEntries-1:0] busy;
    logic [IdxWidth-1:0]  free_idx;
    logic                 none_free;
    entry_t               rsp_entry;

    logic                 alloc_fire;
    logic                 rsp_fwd;
    logic                 rsp_spur;
    logic                 rsp_free;

    logic                 nc_busy_q;
    logic                 nc_busy_d;
    logic [CntWidth-1:0]  count_q;
    logic [CntWidth-1:0]  count_d;

    logic                 rsp_valid_q;
    logic [TagWidth-1:0]  rsp_tag_q;
    logic                 spurious_q;

    logic                 unused_tag_bits;

    // Occupancy vector: an entry is busy unless it is FREE.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NrEntries; i++) begin
            busy[i] = (entries_q[i].state != FREE);
        end
    end

    // Lowest-index FREE entry is the next grant.
    lzc #(
        .WIDTH (NrEntries),
        .MODE  (1'b0)
    ) u_free_lzc (
        .in_i    (~busy),
        .cnt_o   (free_idx),
        .empty_o (none_free)
    );

    assign rsp_entry       = entries_q[rsp_tid_i];
    assign unused_tag_bits = ^rsp_entry.tag;

    // Grant depends on registered state plus the request's own nc bit only.
    assign alloc_ready_o = !flush_i
                        && !none_free
                        && (count_q < CntWidth'(MaxOutstanding))
                        && !nc_busy_q
                        && (!alloc_nc_i || (count_q == '0));

    assign alloc_tid_o = TidWidth'(free_idx);
    assign alloc_fire  = alloc_valid_i && alloc_ready_o;

    // Entry FSMs, nc serialisation flag and in-flight counter next state.
    always_comb begin
        entries_d = entries_q;
        nc_busy_d = nc_busy_q;
        rsp_fwd   = 1'b0;
        rsp_spur  = 1'b0;
        rsp_free  = 1'b0;

        if (flush_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                if (entries_q[i].state == PENDING) begin
                    entries_d[i].state = KILLED;
                end
            end
            // A pending nc entry is killed here, so ordering no longer binds.
            nc_busy_d = 1'b0;
        end

        if (rsp_valid_i) begin
            unique case (rsp_entry.state)
                FREE: begin
                    rsp_spur = 1'b1;
                end
                PENDING, KILLED: begin
                    rsp_free = 1'b1;
                    rsp_fwd  = (rsp_entry.state == PENDING) && !flush_i;
                    if (rsp_entry.nc) begin
                        nc_busy_d = 1'b0;
                    end
                    entries_d[rsp_tid_i].state = FREE;
                end
                default: begin
                    rsp_spur = 1'b0;
                end
            endcase
        end

        // Grant only targets a FREE entry, so it never collides with a free.
        if (alloc_fire) begin
            entries_d[free_idx] = '{
                state: PENDING,
                nc:    alloc_nc_i,
                tag:   MaxTagWidth'(alloc_tag_i)
            };
            if (alloc_nc_i) begin
                nc_busy_d = 1'b1;
            end
        end

        count_d = count_q
                + CntWidth'(alloc_fire)
                - CntWidth'(rsp_free);
    end

    // Tracker state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                entries_q[i] <= '{state: FREE, nc: 1'b0, tag: '0};
            end
            nc_busy_q <= 1'b0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            nc_busy_q <= nc_busy_d;
            count_q   <= count_d;
        end
    end

    // Registered response path: forwarded tag and spurious pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            spurious_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_fwd;
            spurious_q  <= rsp_spur;
            if (rsp_fwd) begin
                rsp_tag_q <= rsp_entry.tag[TagWidth-1:0];
            end
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_tag_o     = rsp_tag_q;
    assign spurious_o    = spurious_q;
    assign outstanding_o = count_q;
    assign empty_o       = (count_q == '0);

    // The counter must stay in range and agree with the entry array.
    a_count_range: assert property (
        @(posedge clk_i) disable iff (rst_i)
        count_q <= CntWidth'(NrEntries)
    );

    a_count_match: assert property (
        @(posedge clk_i) disable iff (rst_i)
        int'(count_q) == $countones(busy)
    );

endmodule

// File: tb/tb_load_tid_tracker.sv
// Self-checking bench for load_tid_tracker: reference model with a
// response scoreboard, plus a MaxOutstanding=3 instance.
module tb_load_tid_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       flush = 1'b0;
    logic       av = 1'b0;
    logic       anc = 1'b0;
    logic [3:0] atag = '0;
    logic       rv = 1'b0;
    logic [2:0] rtid = '0;
    logic       ready;
    logic [2:0] tid;
    logic       rsp_v;
    logic [3:0] rsp_tag;
    logic       spur;
    logic [3:0] outst;
    logic       empty;

    logic       m_flush = 1'b0;
    logic       m_av = 1'b0;
    logic       m_anc = 1'b0;
    logic [3:0] m_atag = '0;
    logic       m_rv = 1'b0;
    logic [2:0] m_rtid = '0;
    logic       m_ready;
    logic [2:0] m_tid;
    logic       m_rsp_v;
    logic [3:0] m_rsp_tag;
    logic       m_spur;
    logic [3:0] m_outst;
    logic       m_empty;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 free, 1 pending, 2 killed.
    int         mst [8];
    logic [3:0] mtag [8];
    logic       mnc [8];
    logic       mncb;
    int         mcnt;
    logic [3:0] sb_q [$];
    logic [3:0] sb_exp;

    always #5 clk = ~clk;

    load_tid_tracker #(
        .NrEntries(8), .TagWidth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .alloc_valid_i(av), .alloc_ready_o(ready),
        .alloc_nc_i(anc), .alloc_tag_i(atag), .alloc_tid_o(tid),
        .rsp_valid_i(rv), .rsp_tid_i(rtid),
        .rsp_valid_o(rsp_v), .rsp_tag_o(rsp_tag),
        .spurious_o(spur), .outstanding_o(outst), .empty_o(empty)
    );

    load_tid_tracker #(
        .NrEntries(8), .TagWidth(4), .MaxOutstanding(3)
    ) dut_m (
        .clk_i(clk), .rst_i(rst), .flush_i(m_flush),
        .alloc_valid_i(m_av), .alloc_ready_o(m_ready),
        .alloc_nc_i(m_anc), .alloc_tag_i(m_atag), .alloc_tid_o(m_tid),
        .rsp_valid_i(m_rv), .rsp_tid_i(m_rtid),
        .rsp_valid_o(m_rsp_v), .rsp_tag_o(m_rsp_tag),
        .spurious_o(m_spur), .outstanding_o(m_outst), .empty_o(m_empty)
    );

    // Scoreboard: every forwarded response must match the queue head,
    // and an expected response must appear exactly one cycle later.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                if (rsp_v !== 1'b1 || rsp_tag !== sb_exp) begin
                    failures++;
                    $display("FAIL rsp_fwd: valid=%b tag=%0d required valid=1 tag=%0d",
                             rsp_v, rsp_tag, sb_exp);
                end
            end else if (rsp_v !== 1'b0) begin
                failures++;
                $display("FAIL rsp_unexpected: valid=%b tag=%0d required valid=0",
                         rsp_v, rsp_tag);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mst[i] = 0;
            mtag[i] = '0;
            mnc[i] = 1'b0;
        end
        mncb = 1'b0;
        mcnt = 0;
        sb_q.delete();
    endtask

    // One cycle of stimulus on the main DUT, checked against the model.
    task automatic drive(input logic a_v, input logic a_nc,
                         input logic [3:0] a_tag, input logic r_v,
                         input logic [2:0] r_tid, input logic fl,
                         output logic granted, output logic [2:0] gtid);
        logic       any_free;
        logic       exp_ready;
        logic [2:0] exp_tid;
        logic       exp_spur;
        any_free = 1'b0;
        exp_tid = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mst[i] == 0) begin
                any_free = 1'b1;
                exp_tid = 3'(i);
            end
        end
        exp_ready = !fl && any_free && (mcnt < 8) && !mncb
                 && (!a_nc || mcnt == 0);
        av = a_v; anc = a_nc; atag = a_tag;
        rv = r_v; rtid = r_tid; flush = fl;
        #1;
        granted = ready;
        gtid = tid;
        checks++;
        if (ready !== exp_ready) begin
            failures++;
            $display("FAIL alloc_ready: got %b required %b", ready, exp_ready);
        end
        if (exp_ready) begin
            checks++;
            if (tid !== exp_tid) begin
                failures++;
                $display("FAIL alloc_tid: got %0d required %0d", tid, exp_tid);
            end
        end
        @(posedge clk);
        exp_spur = 1'b0;
        if (r_v) begin
            if (mst[r_tid] == 0) begin
                exp_spur = 1'b1;
            end else begin
                if (mst[r_tid] == 1 && !fl) sb_q.push_back(mtag[r_tid]);
                if (mnc[r_tid]) mncb = 1'b0;
                mst[r_tid] = 0;
                mcnt--;
            end
        end
        if (fl) begin
            for (int i = 0; i < 8; i++) if (mst[i] == 1) mst[i] = 2;
            mncb = 1'b0;
        end
        if (a_v && exp_ready) begin
            mst[exp_tid] = 1;
            mtag[exp_tid] = a_tag;
            mnc[exp_tid] = a_nc;
            if (a_nc) mncb = 1'b1;
            mcnt++;
        end
        @(negedge clk);
        av = 1'b0; anc = 1'b0; rv = 1'b0; flush = 1'b0;
        checks++;
        if (spur !== exp_spur) begin
            failures++;
            $display("FAIL spurious: got %b required %b", spur, exp_spur);
        end
        checks++;
        if (outst !== 4'(mcnt)) begin
            failures++;
            $display("FAIL outstanding: got %0d required %0d", outst, mcnt);
        end
        checks++;
        if (empty !== (mcnt == 0)) begin
            failures++;
            $display("FAIL empty: got %b required %b", empty, mcnt == 0);
        end
    endtask

    task automatic drain();
        logic       g;
        logic [2:0] t;
        for (int i = 0; i < 8; i++) begin
            if (mst[i] != 0) drive(1'b0, 1'b0, 4'h0, 1'b1, 3'(i), 1'b0, g, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_v !== 1'b0 || rsp_tag !== 4'h0 || spur !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: valid=%b tag=%0d spur=%b required 0 0 0",
                     rsp_v, rsp_tag, spur);
        end
        checks++;
        if (outst !== 4'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_count: outst=%0d empty=%b required 0 1", outst, empty);
        end
        checks++;
        if (ready !== 1'b1 || tid !== 3'd0) begin
            failures++;
            $display("FAIL reset_ready: ready=%b tid=%0d required 1 0", ready, tid);
        end
        checks++;
        if (m_outst !== 4'd0 || m_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_m: outst=%0d ready=%b required 0 1", m_outst, m_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic       g;
        logic [2:0] t;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 4'(i), 1'b0, 3'd0, 1'b0, g, t);
            checks++;
            if (g !== 1'b1 || t !== 3'(i)) begin
                failures++;
                $display("FAIL fill_grant: ready=%b tid=%0d required 1 %0d", g, t, i);
            end
        end
        drive(1'b1, 1'b0, 4'h8, 1'b0, 3'd0, 1'b0, g, t);
        checks++;
        if (g !== 1'b0 || outst !== 4'd8) begin
            failures++;
            $display("FAIL fill_full: ready=%b outst=%0d required 0 8", g, outst);
        end
    endtask

    task automatic test_out_of_order();
        logic       g;
        logic [2:0] t;
        drive(1'b0, 1'b0, 4'h0, 1'b1, 3'd5, 1'b0, g, t);
        checks++;
        if (rsp_v !== 1'b1 || rsp_tag !== 4'd5) begin
            failures++;
            $display("FAIL ooo_first: valid=%b tag=%0d required 1 5", rsp_v, rsp_tag);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0, g, t);
        checks++;
        if (t !== 3'd5 || rsp_tag !== 4'd2) begin
            failures++;
            $display("FAIL ooo_second: tid=%0d tag=%0d required 5 2", t, rsp_tag);
        end
        drive(1'b1, 1'b0, 4'h9, 1'b0, 3'd0, 1'b0, g, t);
        checks++;
        if (g !== 1'b1 || t !== 3'd2) begin
            failures++;
            $display("FAIL ooo_realloc: ready=%b tid=%0d required 1 2", g, t);
        end
        drive(1'b1, 1'b0, 4'hA, 1'b1, 3'd0, 1'b0, g, t);
        checks++;
        if (t !== 3'd5 || outst !== 4'd7) begin
            failures++;
            $display("FAIL alloc_and_rsp: tid=%0d outst=%0d required 5 7", t, outst);
        end
        drain();
    endtask

    task automatic test_flush();
        logic       g;
        logic [2:0] t;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'(i + 4), 1'b0, 3'd0, 1'b0, g, t);
        drive(1'b1, 1'b0, 4'hF, 1'b0, 3'd0, 1'b1, g, t);
        checks++;
        if (g !== 1'b0 || outst !== 4'd4) begin
            failures++;
            $display("FAIL flush_block: ready=%b outst=%0d required 0 4", g, outst);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'h0, 1'b1, 3'(i), 1'b0, g, t);
            checks++;
            if (rsp_v !== 1'b0 || outst !== 4'(3 - i)) begin
                failures++;
                $display("FAIL flush_drop: valid=%b outst=%0d required 0 %0d",
                         rsp_v, outst, 3 - i);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: got %b required 1", empty);
        end
    endtask

    task automatic test_flush_same_cycle();
        logic       g;
        logic [2:0] t;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'(i + 1), 1'b0, 3'd0, 1'b0, g, t);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 1'b1, g, t);
        checks++;
        if (rsp_v !== 1'b0 || outst !== 4'd2) begin
            failures++;
            $display("FAIL flush_same: valid=%b outst=%0d required 0 2", rsp_v, outst);
        end
        drain();
    endtask

    task automatic test_nc();
        logic       g;
        logic [2:0] t;
        drive(1'b1, 1'b0, 4'h1, 1'b0, 3'd0, 1'b0, g, t);
        drive(1'b1, 1'b0, 4'h2, 1'b0, 3'd0, 1'b0, g, t);
        drive(1'b1, 1'b1, 4'hC, 1'b1, 3'd0, 1'b0, g, t);
        checks++;
        if (g !== 1'b0) begin
            failures++;
            $display("FAIL nc_hold2: ready=%b required 0", g);
        end
        drive(1'b1, 1'b1, 4'hC, 1'b1, 3'd1, 1'b0, g, t);
        checks++;
        if (g !== 1'b0) begin
            failures++;
            $display("FAIL nc_hold1: ready=%b required 0", g);
        end
        drive(1'b1, 1'b1, 4'hC, 1'b0, 3'd0, 1'b0, g, t);
        checks++;
        if (g !== 1'b1 || t !== 3'd0) begin
            failures++;
            $display("FAIL nc_grant: ready=%b tid=%0d required 1 0", g, t);
        end
        drive(1'b1, 1'b0, 4'hD, 1'b0, 3'd0, 1'b0, g, t);
        drive(1'b1, 1'b0, 4'hD, 1'b1, 3'd0, 1'b0, g, t);
        checks++;
        if (g !== 1'b0) begin
            failures++;
            $display("FAIL nc_block: ready=%b required 0", g);
        end
        drive(1'b1, 1'b0, 4'hD, 1'b0, 3'd0, 1'b0, g, t);
        checks++;
        if (g !== 1'b1 || t !== 3'd0) begin
            failures++;
            $display("FAIL nc_resume: ready=%b tid=%0d required 1 0", g, t);
        end
        drain();
    endtask

    task automatic test_spurious();
        logic       g;
        logic [2:0] t;
        drive(1'b0, 1'b0, 4'h0, 1'b1, 3'd6, 1'b0, g, t);
        checks++;
        if (spur !== 1'b1 || rsp_v !== 1'b0 || outst !== 4'd0) begin
            failures++;
            $display("FAIL spur_pulse: spur=%b valid=%b outst=%0d required 1 0 0",
                     spur, rsp_v, outst);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, g, t);
        checks++;
        if (spur !== 1'b0) begin
            failures++;
            $display("FAIL spur_one_cycle: spur=%b required 0", spur);
        end
    endtask

    task automatic test_reset_mid();
        logic       g;
        logic [2:0] t;
        drive(1'b1, 1'b0, 4'h3, 1'b0, 3'd0, 1'b0, g, t);
        drive(1'b1, 1'b0, 4'h4, 1'b0, 3'd0, 1'b0, g, t);
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (outst !== 4'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: outst=%0d empty=%b required 0 1", outst, empty);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0, g, t);
        checks++;
        if (spur !== 1'b1 || rsp_v !== 1'b0) begin
            failures++;
            $display("FAIL late_rsp: spur=%b valid=%b required 1 0", spur, rsp_v);
        end
    endtask

    task automatic test_max_outstanding();
        for (int i = 0; i < 3; i++) begin
            m_av = 1'b1;
            m_atag = 4'(i + 10);
            #1;
            checks++;
            if (m_ready !== 1'b1 || m_tid !== 3'(i)) begin
                failures++;
                $display("FAIL cap_grant: ready=%b tid=%0d required 1 %0d", m_ready, m_tid, i);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (m_ready !== 1'b0) begin
            failures++;
            $display("FAIL cap_refuse: ready=%b required 0", m_ready);
        end
        m_av = 1'b0;
        m_rv = 1'b1;
        m_rtid = 3'd5;
        @(negedge clk);
        m_rv = 1'b0;
        checks++;
        if (m_spur !== 1'b1 || m_rsp_v !== 1'b0 || m_outst !== 4'd3) begin
            failures++;
            $display("FAIL cap_spur: spur=%b valid=%b outst=%0d required 1 0 3",
                     m_spur, m_rsp_v, m_outst);
        end
        @(negedge clk);
        checks++;
        if (m_spur !== 1'b0 || m_outst !== 4'd3 || m_ready !== 1'b0) begin
            failures++;
            $display("FAIL cap_after_spur: spur=%b outst=%0d ready=%b required 0 3 0",
                     m_spur, m_outst, m_ready);
        end
        m_rv = 1'b1;
        m_rtid = 3'd0;
        @(negedge clk);
        m_rv = 1'b0;
        checks++;
        if (m_rsp_v !== 1'b1 || m_rsp_tag !== 4'd10 || m_outst !== 4'd2) begin
            failures++;
            $display("FAIL cap_rsp: valid=%b tag=%0d outst=%0d required 1 10 2",
                     m_rsp_v, m_rsp_tag, m_outst);
        end
        checks++;
        if (m_ready !== 1'b1 || m_tid !== 3'd0) begin
            failures++;
            $display("FAIL cap_reopen: ready=%b tid=%0d required 1 0", m_ready, m_tid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_out_of_order();
        test_flush();
        test_flush_same_cycle();
        test_nc();
        test_spurious();
        test_max_outstanding();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: %0d entries required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
